// File: rtl/riscv_pkg.sv
// Shared definitions for the load/store unit.
// Contents:
//   MEM_*          memory access mode encodings (mem_acc_mode)
//   lsu_state_t    LSU controller FSM states
//   LSU_TIMEOUT    number of BUSY cycles without ack before a bus error
//   is_misaligned  alignment check for a given mode and byte offset
package riscv_pkg;

    localparam logic [2:0] MEM_B    = 3'b000;
    localparam logic [2:0] MEM_H    = 3'b001;
    localparam logic [2:0] MEM_W    = 3'b010;
    localparam logic [2:0] MEM_BU   = 3'b011;
    localparam logic [2:0] MEM_HU   = 3'b100;
    localparam logic [2:0] MEM_NONE = 3'b111;

    localparam int LSU_TIMEOUT = 255;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUSY = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_t;

    // Halfwords need an even address, words a 4-byte aligned address.
    function automatic logic is_misaligned(input logic [2:0] mode, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (mode)
            MEM_H, MEM_HU: mis = off[0];
            MEM_W:         mis = (off != 2'b00);
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Word-wide memory bus between the LSU (master) and memory (slave).
// Signals:
//   bus_req    master->slave  access in progress
//   bus_we     master->slave  1 = write
//   bus_addr   master->slave  word-aligned address
//   bus_wdata  master->slave  replicated store data
//   bus_mask   master->slave  byte enables (0 for reads)
//   bus_ack    slave->master  one-cycle completion strobe
//   bus_rdata  slave->master  word read data, valid with bus_ack
interface lsu_ctrl_if;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_mask;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_mask,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_mask,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/lsu_load_align.sv
// Load lane select and extension.
// Ports:
//   word    in  32  raw word from the bus
//   offset  in  2   byte offset of the access within the word
//   mode    in  3   access mode (B/H signed, BU/HU unsigned, W)
//   data    out 32  extended load result
module lsu_load_align
    import riscv_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  mode,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    function automatic logic [31:0] sext8(input logic [7:0] v);
        logic signed [7:0] s;
        s = v;
        return 32'(s);
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] v);
        logic signed [15:0] s;
        s = v;
        return 32'(s);
    endfunction

    always_comb begin
        byte_lane = word[7:0];
        case (offset)
            2'd0: byte_lane = word[7:0];
            2'd1: byte_lane = word[15:8];
            2'd2: byte_lane = word[23:16];
            2'd3: byte_lane = word[31:24];
            default: byte_lane = word[7:0];
        endcase
        half_lane = offset[1] ? word[31:16] : word[15:0];

        data = word;
        case (mode)
            MEM_B:   data = sext8(byte_lane);
            MEM_BU:  data = {24'd0, byte_lane};
            MEM_H:   data = sext16(half_lane);
            MEM_HU:  data = {16'd0, half_lane};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: turns one decoded load/store into a single
// word-bus transaction, stalling the pipeline until it completes.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rd_en, wr_en             load / store request (store wins if both)
//   mem_acc_mode             B/H/W/BU/HU/none
//   addr, wdata              effective address, store data
//   stall                    freeze the pipeline
//   done                     one-cycle completion pulse
//   misaligned               alignment fault (combinational, no bus activity)
//   bus_err                  timeout fault, pulses with done
//   rdata                    extended load data (held between accesses)
//   bus                      memory bus, master side
module lsu_ctrl
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [2:0]  mem_acc_mode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic        misaligned,
    output logic        bus_err,
    output logic [31:0] rdata,
    lsu_ctrl_if.master  bus
);

    lsu_state_t  state, state_nxt;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [2:0]  mode_q;
    logic        we_q;
    logic [7:0]  cnt_q;
    logic        err_q;

    logic        acc_valid, acc_misal, launch, timeout;
    logic [31:0] load_data;

    function automatic logic [3:0] store_mask(input logic [2:0] mode, input logic [1:0] off);
        logic [3:0] m;
        m = 4'b0000;
        case (mode)
            MEM_B:   m = 4'b0001 << off;
            MEM_H:   m = 4'b0011 << {off[1], 1'b0};
            MEM_W:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] mode, input logic [31:0] d);
        logic [31:0] r;
        r = d;
        case (mode)
            MEM_B:   r = {4{d[7:0]}};
            MEM_H:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // Stores only support signed-mode encodings B/H/W.
    assign acc_valid = (rd_en | wr_en) && (mem_acc_mode != MEM_NONE) &&
                       (!wr_en || (mem_acc_mode inside {MEM_B, MEM_H, MEM_W}));
    assign acc_misal = is_misaligned(mem_acc_mode, addr[1:0]);
    assign launch    = (state == LSU_IDLE) && acc_valid && !acc_misal;
    // cnt_q counts BUSY cycles already spent, so this is the last allowed one.
    assign timeout   = (state == LSU_BUSY) && !bus.bus_ack &&
                       (cnt_q == 8'(LSU_TIMEOUT - 1));

    lsu_load_align u_align (
        .word   (bus.bus_rdata),
        .offset (addr_q[1:0]),
        .mode   (mode_q),
        .data   (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= LSU_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LSU_IDLE: if (launch) state_nxt = LSU_BUSY;
            LSU_BUSY: if (bus.bus_ack || timeout) state_nxt = LSU_DONE;
            // DONE never relaunches: the held instruction is retiring.
            LSU_DONE: state_nxt = LSU_IDLE;
            default:  state_nxt = LSU_IDLE;
        endcase
    end

    always_comb begin
        stall         = launch || (state == LSU_BUSY);
        done          = (state == LSU_DONE);
        misaligned    = (state == LSU_IDLE) && acc_valid && acc_misal;
        bus_err       = (state == LSU_DONE) && err_q;
        bus.bus_req   = (state == LSU_BUSY);
        bus.bus_we    = (state == LSU_BUSY) && we_q;
        bus.bus_addr  = {addr_q[31:2], 2'b00};
        bus.bus_mask  = we_q ? store_mask(mode_q, addr_q[1:0]) : 4'b0000;
        bus.bus_wdata = store_data(mode_q, wdata_q);
        rdata         = rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            mode_q  <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= timeout;
            if (launch) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                mode_q  <= mem_acc_mode;
                we_q    <= wr_en;
                cnt_q   <= '0;
            end else if (state == LSU_BUSY) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (state == LSU_BUSY) begin
                if (bus.bus_ack) begin
                    if (!we_q) rdata_q <= load_data;
                end else if (timeout) begin
                    rdata_q <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus randomized
// accesses checked against a behavioural model of the access rules.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [2:0]  mem_acc_mode;
    logic [31:0] addr, wdata;
    logic        stall, done, misaligned, bus_err;
    logic [31:0] rdata;

    int checks   = 0;
    int failures = 0;
    int tx_count = 0;
    logic req_prev = 1'b0;
    logic [31:0] exp_rdata;

    lsu_ctrl_if bus_if ();

    lsu_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .rd_en        (rd_en),
        .wr_en        (wr_en),
        .mem_acc_mode (mem_acc_mode),
        .addr         (addr),
        .wdata        (wdata),
        .stall        (stall),
        .done         (done),
        .misaligned   (misaligned),
        .bus_err      (bus_err),
        .rdata        (rdata),
        .bus          (bus_if)
    );

    always #5 clk = ~clk;

    // Count bus transactions as rising edges of bus_req.
    always @(posedge clk) begin
        if (bus_if.bus_req && !req_prev) tx_count = tx_count + 1;
        req_prev = bus_if.bus_req;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] m_mask(input logic [2:0] mode, input logic [31:0] a);
        if (mode == 3'd0) return 4'(1 << (a % 4));
        if (mode == 3'd1) return 4'(3 << (a & 2));
        if (mode == 3'd2) return 4'hF;
        return 4'h0;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] mode, input logic [31:0] d);
        if (mode == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (mode == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] mode, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * (a % 4))) & 32'hFF;
        h = (w >> (8 * (a & 2))) & 32'hFFFF;
        case (mode)
            3'd0: return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            3'd3: return b;
            3'd1: return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3'd4: return h;
            default: return w;
        endcase
    endfunction

    // One instruction: inputs held through IDLE/BUSY/DONE, dropped afterwards.
    // nwait < 0 means the slave never acks.
    task automatic access(input logic rd, input logic wr, input logic [2:0] mode,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int nwait, input logic [31:0] word, output int stalls);
        logic valid, mis;
        int   start_tx, nbusy;
        valid = (rd || wr) && (mode != 3'b111) && (!wr || mode <= 3'b010);
        mis   = ((mode == 3'd1 || mode == 3'd4) && a[0]) || (mode == 3'd2 && a[1:0] != 2'b00);
        stalls = 0;
        start_tx = tx_count;
        @(posedge clk); #1;
        rd_en = rd; wr_en = wr; mem_acc_mode = mode; addr = a; wdata = wd;
        bus_if.bus_ack = 1'b0;
        if (!valid || mis) begin
            // A stray ack while idle must not disturb anything.
            bus_if.bus_ack = 1'b1; bus_if.bus_rdata = $urandom;
            @(negedge clk);
            chk("idle_stall", 32'(stall), 0);
            chk("misaligned", 32'(misaligned), 32'(valid && mis));
            chk("idle_req", 32'(bus_if.bus_req), 0);
            @(posedge clk); #1;
            rd_en = 0; wr_en = 0; bus_if.bus_ack = 1'b0;
            @(negedge clk);
            chk("idle_req_after", 32'(bus_if.bus_req), 0);
            chk("idle_rdata_hold", rdata, exp_rdata);
            chk("idle_no_tx", 32'(tx_count - start_tx), 0);
            return;
        end
        @(negedge clk);
        chk("req_stall", 32'(stall), 1);
        chk("req_misaligned", 32'(misaligned), 0);
        chk("req_bus_req", 32'(bus_if.bus_req), 0);
        stalls = 1;
        nbusy = (nwait < 0) ? 255 : nwait + 1;
        for (int c = 0; c < nbusy; c++) begin
            @(posedge clk); #1;
            bus_if.bus_ack   = (c == nwait);
            bus_if.bus_rdata = (c == nwait) ? word : $urandom;
            @(negedge clk);
            if (stall) stalls++;
            chk("busy_req", 32'(bus_if.bus_req), 1);
            chk("busy_done", 32'(done), 0);
            if (c == 0) begin
                chk("bus_addr", bus_if.bus_addr, a & 32'hFFFF_FFFC);
                chk("bus_we", 32'(bus_if.bus_we), 32'(wr));
                chk("bus_mask", 32'(bus_if.bus_mask), wr ? 32'(m_mask(mode, a)) : 0);
                if (wr) chk("bus_wdata", bus_if.bus_wdata, m_wdata(mode, wd));
            end
        end
        @(posedge clk); #1;
        bus_if.bus_ack = 1'b0;
        if (nwait < 0)  exp_rdata = 0;
        else if (!wr)   exp_rdata = m_load(mode, a, word);
        @(negedge clk);
        if (stall) stalls++;
        chk("done_pulse", 32'(done), 1);
        chk("done_req", 32'(bus_if.bus_req), 0);
        chk("done_bus_err", 32'(bus_err), 32'(nwait < 0));
        chk("done_rdata", rdata, exp_rdata);
        @(posedge clk); #1;
        rd_en = 0; wr_en = 0;
        @(negedge clk);
        chk("after_done", 32'(done), 0);
        chk("after_err", 32'(bus_err), 0);
        chk("after_stall", 32'(stall), 0);
        chk("rdata_hold", rdata, exp_rdata);
        chk("one_tx", 32'(tx_count - start_tx), 1);
    endtask

    initial begin
        int st;
        logic [2:0] modes [6];
        modes = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
        rst = 1'b1; rd_en = 0; wr_en = 0; mem_acc_mode = 3'b111;
        addr = 0; wdata = 0; bus_if.bus_ack = 0; bus_if.bus_rdata = 0;
        exp_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_bus_req", 32'(bus_if.bus_req), 0);
        chk("rst_bus_err", 32'(bus_err), 0);
        chk("rst_rdata", rdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // LB at offset 3, two wait cycles
        access(1, 0, 3'd0, 32'h0000_1003, 0, 2, 32'h80AA_BBCC, st);
        chk("lb_stall_cycles", 32'(st), 4);
        chk("lb_rdata", rdata, 32'hFFFF_FF80);
        // SH to upper half
        access(0, 1, 3'd1, 32'h0000_2002, 32'h0000_BEEF, 0, 0, st);
        chk("sh_stall_cycles", 32'(st), 2);
        // Misaligned LW
        access(1, 0, 3'd2, 32'h0000_3001, 0, 0, 0, st);
        // Store priority over load with both enables
        access(1, 1, 3'd2, 32'h0000_2100, 32'h1234_5678, 1, 32'hDEAD_BEEF, st);
        // LHU timeout
        access(1, 0, 3'd4, 32'h0000_4002, 0, -1, 0, st);
        chk("timeout_stall_cycles", 32'(st), 256);
        // Store with BU mode is invalid
        access(0, 1, 3'd3, 32'h0000_5000, 32'hFFFF_FFFF, 0, 0, st);

        // Reset while BUSY, then a late ack
        access(1, 0, 3'd2, 32'h0000_6000, 0, 0, 32'h0BAD_F00D, st);
        @(posedge clk); #1;
        rd_en = 1; mem_acc_mode = 3'd2; addr = 32'h0000_7000;
        @(negedge clk);
        chk("rb_stall", 32'(stall), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rb_busy_req", 32'(bus_if.bus_req), 1);
        rst = 1'b1; rd_en = 0;
        @(posedge clk); #1;
        rst = 1'b0; bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h1234_5678;
        exp_rdata = 0;
        @(negedge clk);
        chk("rb_req_dropped", 32'(bus_if.bus_req), 0);
        chk("rb_stall_dropped", 32'(stall), 0);
        chk("rb_no_done", 32'(done), 0);
        @(posedge clk); #1;
        bus_if.bus_ack = 1'b0;
        @(negedge clk);
        chk("rb_no_done2", 32'(done), 0);
        chk("rb_rdata", rdata, 0);

        // Randomized accesses
        for (int i = 0; i < 60; i++) begin
            logic [2:0] m;
            m = modes[$urandom_range(0, 5)];
            access(1'($urandom), 1'($urandom), m, $urandom, $urandom,
                   int'($urandom_range(0, 3)), $urandom, st);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: rd_en  in  1  load request from decoder; wr_en  in  1  store request from decoder.
REQ-004 SHALL have ports: mem_acc_mode  in  3  000 B, 001 H, 010 W, 011 BU, 100 HU, 111 none.
REQ-005 SHALL have ports: addr  in  32  effective address (ALU result); wdata  in  32  store data (rs2).
REQ-006 SHALL have ports: stall  out  1  freeze PC/pipeline; done  out  1  access complete; misaligned  out  1  alignment fault.
REQ-007 SHALL have ports: bus_err  out  1  timeout fault; rdata  out  32  extended load data to writeback.
REQ-008 SHALL have ports: bus_req  out  1; bus_we  out  1; bus_addr  out  32; bus_wdata  out  32; bus_mask  out  4.
REQ-009 SHALL have ports: bus_ack  in  1  one-cycle completion; bus_rdata  in  32  word read data, valid with bus_ack.

Function
REQ-010 SHALL implement FSM IDLE, BUSY, DONE; reset state IDLE.
REQ-011 Access valid SHALL be defined as (rd_en|wr_en) & mode!=111 & (wr_en implies mode in {000,001,010}); else no bus activity, no stall.
REQ-012 If rd_en and wr_en are both high, the store SHALL take priority.
REQ-013 Misaligned SHALL be defined as H/HU with addr[0]=1, or W with addr[1:0]!=00; a valid misaligned access in IDLE SHALL assert misaligned combinationally that cycle, with no bus request, no stall, and the FSM staying IDLE.
REQ-014 A valid aligned access in IDLE SHALL assert stall combinationally, capture addr, mode, wdata and we, and go to BUSY next edge.
REQ-015 In BUSY: bus_req=1 (registered); bus_addr={addr_q[31:2],2'b00}; bus_we=we_q; stall=1.
REQ-016 bus_mask SHALL be: B 4'b0001<<addr_q[1:0]; H 4'b0011<<{addr_q[1],1'b0}; W 4'b1111; 0 when loading.
REQ-017 bus_wdata SHALL be: B {4{wdata_q[7:0]}}; H {2{wdata_q[15:0]}}; W wdata_q.
REQ-018 bus_ack in BUSY SHALL register aligned/extended load data into rdata_q and go to DONE; bus_ack outside BUSY SHALL be ignored.
REQ-019 Load extension SHALL select the lane by addr_q[1:0]; B/H sign-extended, BU/HU zero-extended, W unmodified.
REQ-020 In DONE: stall=0, done=1 for exactly one cycle, rdata=rdata_q; the FSM SHALL return to IDLE and ignore rd_en/wr_en that cycle (no relaunch of the held instruction).
REQ-021 An 8-bit timeout counter SHALL clear on BUSY entry and increment each BUSY cycle; at 255 without ack, bus_err SHALL pulse one cycle, rdata_q SHALL be 0, and the FSM SHALL go to DONE.
REQ-022 Latency SHALL be: request cycle + N wait cycles until ack + DONE cycle; minimum stall 2 cycles (ack in first BUSY cycle).
REQ-023 rdata SHALL hold its last value outside DONE.

Reset
REQ-024 On rst=1 at a clock edge, the FSM SHALL go to IDLE and clear addr_q, wdata_q, rdata_q, we_q and the counter.
REQ-025 After reset, bus_req, done, bus_err and stall SHALL be 0, and rdata SHALL be 0.
REQ-026 Reset asserted during BUSY SHALL drop bus_req on that edge; a subsequent bus_ack SHALL be ignored.

Structure
REQ-027 The shared package riscv_pkg SHALL hold the mem_acc_mode localparams, the lsu_state_t enum and LSU_TIMEOUT=255.
REQ-028 Combinational lane select and extend SHALL be the sub-module lsu_load_align (inputs: word, offset, mode; output: 32-bit data).

Verification
REQ-029 LB addr=0x1003, bus_rdata=0x80AABBCC, ack after 2 waits -> stall 4 cycles, done pulse, rdata=0xFFFFFF80.
REQ-030 SH addr=0x2002, wdata=0x0000BEEF -> bus_mask=1100, bus_wdata=0xBEEFBEEF, bus_we=1, bus_addr=0x2000.
REQ-031 LW addr=0x3001 -> misaligned=1 same cycle, bus_req never asserted, stall=0.
REQ-032 LHU addr=0x4002 with no ack -> bus_err pulse after 255 BUSY cycles, done=1, rdata=0.
REQ-033 rst during BUSY with ack one cycle later -> bus_req=0 after the reset edge, FSM IDLE, no done pulse.
REQ-034 rd_en held high through DONE -> exactly one bus_req transaction per instruction.
